mmss_timer: RTL
===============

# mmss_timer

Parametrised minutes:seconds timer. It generalises the plain 0–99 minutes counter into a self-timed stopwatch/countdown with an internal clock prescaler, an up/down mode, wrap or saturate behaviour at the terminal value, a preset load, and start/stop control. It sits between the system clock domain and the display/alarm logic, and drives binary `minutes`/`seconds` fields plus `tick`, `rollover` and `done` status.

## Interface
Parameters:
- `CLK_DIV`, default 1000: number of clk cycles per one-second step; must be ≥ 1.
- `MIN_MAX`, default 99: maximum minutes value; must be ≥ 1.
- `MIN_W`: derived localparam, equal to `$clog2(MIN_MAX+1)`; not overridable.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous clear to 00:00, stopped.
- `load`  in  1  synchronous preset from `load_min`/`load_sec`, stopped.
- `load_min`  in  MIN_W  preset minutes.
- `load_sec`  in  6  preset seconds.
- `start`  in  1  begin/resume counting.
- `stop`  in  1  pause counting.
- `dir`  in  1  0 = count up, 1 = count down; sampled at each step.
- `wrap_en`  in  1  1 = wrap at the terminal value, 0 = stop at the terminal value and flag `done`.
- `minutes`  out  MIN_W  current minutes, range 0..MIN_MAX.
- `seconds`  out  6  current seconds, range 0..59.
- `running`  out  1  high in RUN.
- `tick`  out  1  one-cycle pulse on every value step.
- `rollover`  out  1  one-cycle pulse on a wrap step.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Control priority per edge: `rst_n` > `clear` > `load` > `stop` > `start` > step.
- Reset:
  - Value is 00:00; prescaler is 0; state is IDLE.
  - `running`, `tick`, `rollover` and `done` are all 0.
- `clear`: from any state, value goes to 00:00, state to IDLE, prescaler to 0.
- `load`:
  - From any state, state goes to IDLE and the prescaler to 0.
  - Value becomes `min(load_min, MIN_MAX)`:`min(load_sec, 59)`.
  - A simultaneous `clear` wins.
- `start`:
  - In IDLE, the state goes to RUN and the prescaler is held at 0.
  - Exception: if `dir`=1, `wrap_en`=0 and the value is 00:00, the state goes directly to DONE.
  - Ignored in RUN and in DONE.
- `stop`:
  - In RUN, the state goes to IDLE. The value is held and the prescaler is reset to 0; fractional seconds are discarded.
  - Ignored elsewhere.
  - `start` and `stop` in the same cycle: `stop` wins, so an IDLE block stays IDLE.
- Prescaler: in RUN it counts 0..CLK_DIV-1. At CLK_DIV-1 it returns to 0 and one step occurs. Outside RUN it is held at 0.
- Up step (`dir`=0):
  - `seconds` < 59: `seconds` + 1.
  - Otherwise `seconds` goes to 0 and `minutes` + 1.
  - At MIN_MAX:59 with `wrap_en`=1: value goes to 00:00, `rollover` pulses, state stays RUN.
  - At MIN_MAX:59 with `wrap_en`=0: value holds, no `tick` is issued, state goes to DONE.
- Down step (`dir`=1):
  - `seconds` > 0: `seconds` - 1.
  - Otherwise `seconds` goes to 59 and `minutes` - 1.
  - If the step lands on 00:00 and `wrap_en`=0: state goes to DONE in the same edge; `tick` pulses.
  - At 00:00 with `wrap_en`=1: value goes to MIN_MAX:59 and `rollover` pulses.
- DONE: the value is frozen. Only `clear`, `load` or reset exit DONE, each to IDLE.
- Changes to `dir` and `wrap_en` mid-run take effect at the next step.

## Timing
- Start accepted at edge n: `running`=1 after edge n. The first step occurs at edge n+CLK_DIV; each further step follows every CLK_DIV edges.
- `tick` and `rollover` are high for exactly the one cycle after the step edge, coincident with the new value being visible.
- `done` and `running` update on the same edge as the state change.
- With `CLK_DIV`=1, a step occurs on every RUN edge.
- `rst_n` assertion mid-run forces all outputs to their reset values immediately (asynchronously). Deassertion is synchronous to `clk`.
- `clear`/`load` during a `tick` cycle: the `tick`/`rollover` pulse still ends after one cycle, and no further step occurs.

## Test plan
Parameters for all scenarios: CLK_DIV=4, MIN_MAX=2.
- Reset mid-run at value 1:17: outputs read 0:00 before the next edge; `running`=`tick`=`done`=0.
- Up count, `wrap_en`=0, start from 00:00:
  - First `tick` arrives 4 cycles after start, with `seconds`=1.
  - After 179 ticks the value is 2:59.
  - The next step edge gives `done`=1 and `running`=0, with the value held at 2:59.
- Up count, `wrap_en`=1, from 2:59: the next step gives 0:00, with `rollover`=1 for one cycle and `running` still 1.
- Down count: `load` 1:05, `dir`=1, start.
  - The sequence passes 1:00 → 0:59.
  - After 65 ticks the value is 0:00 and `done`=1.
  - Starting again in DONE is ignored.
- Clamp and pause:
  - `load_min`=3, `load_sec`=63 → 2:59.
  - Stop at prescaler=2, then start: the next tick arrives exactly 4 cycles after the restart.
- Simultaneous events:
  - `clear`+`load` in the same cycle → 0:00.
  - `start`+`stop` in IDLE → stays IDLE.
  - `dir`=1, `wrap_en`=0, start at 0:00 → `done`=1 on the next edge.

Source files
------------

// File: rtl/mmss_timer.sv
// Minutes:seconds stopwatch/countdown with an internal one-second prescaler.
// It counts up or down, then wraps or stops at the terminal value. It also supports a preset load and start/stop control.
`timescale 1ns/1ps
module mmss_timer #(
    parameter int CLK_DIV = 1000,
    parameter int MIN_MAX = 99,
    localparam int MIN_W = $clog2(MIN_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [5:0]       load_sec,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             wrap_en,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic             running,
    output logic             tick,
    output logic             rollover,
    output logic             done
);

    // A single-cycle prescaler still needs one bit so that the vector is legal.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [MIN_W-1:0] MIN_TOP    = MIN_W'(MIN_MAX);
    localparam logic [5:0]       SEC_TOP    = 6'd59;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic [MIN_W-1:0] min_nxt;
    logic [5:0]       sec_nxt;
    logic             tick_nxt, roll_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            presc    <= '0;
            minutes  <= '0;
            seconds  <= '0;
            tick     <= 1'b0;
            rollover <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            minutes  <= min_nxt;
            seconds  <= sec_nxt;
            tick     <= tick_nxt;
            rollover <= roll_nxt;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

    always_comb begin
        state_nxt = state;
        presc_nxt = '0;
        min_nxt   = minutes;
        sec_nxt   = seconds;
        tick_nxt  = 1'b0;
        roll_nxt  = 1'b0;

        if (clear) begin
            state_nxt = IDLE;
            min_nxt   = '0;
            sec_nxt   = '0;
        end else if (load) begin
            state_nxt = IDLE;
            min_nxt   = (load_min > MIN_TOP) ? MIN_TOP : load_min;
            sec_nxt   = (load_sec > SEC_TOP) ? SEC_TOP : load_sec;
        end else if (stop) begin
            // A stop also masks a same-cycle start, so IDLE stays IDLE.
            if (state == RUN)
                state_nxt = IDLE;
        end else if (start && state == IDLE) begin
            if (dir && !wrap_en && minutes == '0 && seconds == '0)
                state_nxt = DONE;
            else
                state_nxt = RUN;
        end else if (state == RUN) begin
            if (presc != PRESC_LAST) begin
                presc_nxt = presc + PW'(1);
            end else if (!dir) begin
                if (seconds != SEC_TOP) begin
                    sec_nxt  = seconds + 6'd1;
                    tick_nxt = 1'b1;
                end else if (minutes != MIN_TOP) begin
                    sec_nxt  = '0;
                    min_nxt  = minutes + MIN_W'(1);
                    tick_nxt = 1'b1;
                end else if (wrap_en) begin
                    sec_nxt  = '0;
                    min_nxt  = '0;
                    tick_nxt = 1'b1;
                    roll_nxt = 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end else begin
                if (seconds != '0) begin
                    sec_nxt  = seconds - 6'd1;
                    tick_nxt = 1'b1;
                    if (!wrap_en && minutes == '0 && seconds == 6'd1)
                        state_nxt = DONE;
                end else if (minutes != '0) begin
                    sec_nxt  = SEC_TOP;
                    min_nxt  = minutes - MIN_W'(1);
                    tick_nxt = 1'b1;
                end else if (wrap_en) begin
                    sec_nxt  = SEC_TOP;
                    min_nxt  = MIN_TOP;
                    tick_nxt = 1'b1;
                    roll_nxt = 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end
        end
    end

endmodule
